mlp_controller: RTL and testbench
=================================

# mlp_controller

Sequencing FSM that drives the control bus of the MLP datapath: loads one input sample and all weight/bias registers, runs the 8 processing units (PUs) over 4 hidden-layer groups and 2 output-layer groups, and writes each result into the hidden and output result registers. It sits between the top-level start/done handshake and the datapath. The datapath's argmax `out` is valid from the cycle `done` pulses.

## Interface
- `N_HID`, 30: hidden neurons, which is also the number of weight registers.
- `N_OUT`, 10: output neurons.
- `N_PU`, 8: processing units.
- `clk`  in  1: the only clock.
- `rst`  in  1: synchronous reset, active-high.
- `start`  in  1: begins one inference. Sampled only in IDLE.
- `sample_idx`  in  10: data-memory address of the sample. Latched when `start` is accepted.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `done`  out  1: one-cycle pulse when the output registers hold the final result.
- `mem_read`, `ld_x`, `sel_h_o`, `acc`, `ld_add`, `ld_mult`, `rst_cnt`, `cnt`  out  1 each: datapath controls.
- `addr1`  out  5: hidden-layer weight/bias memory address.
- `addr2`  out  4: output-layer weight/bias memory address.
- `addr3`  out  10: sample memory address.
- `sel_64bit`  out  3: selects one 64-bit chunk.
- `sel_reg`  out  3: PU group select.
- `ld`  out  30, `ld_out_h`  out  30, `ld_out_o`  out  10: load enables.

## Operation
- Reset value of every output is 0.
- `rst` asserted at any point, including mid-inference, puts the FSM in IDLE on the next edge with all outputs 0 and no `done`.
- Any output not named for a state below is 0 in that state.
- States, in order:
  - IDLE: wait for `start`.
  - LOAD_X, 1 cycle: `mem_read`=1, `addr3`=latched index, `ld_x`=1, `sel_h_o`=0.
  - LOAD_WH, 30 cycles: `addr1`=k and `ld[k]`=1 for k=0..29, with `mem_read`=1 and `sel_h_o`=0.
  - HID_GRP for g=0..3, each as CLR → RUN(base 0, N=8) → WB:
    - WB sets `ld_out_h[g*8+i]`=1 for i=0..7 where g*8+i<30.
    - Group 3 therefore writes bits 24..29 only.
  - LOAD_WO, 10 cycles: `sel_h_o`=1, `mem_read`=1, `addr2`=k, `ld[k]`=1 for k=0..9.
  - LOAD_XO, 1 cycle: `sel_h_o`=1, `ld_x`=1. This captures the hidden results.
  - OUT_GRP for g=0..1, each as CLR → RUN(base 4, N=4) → WB:
    - WB sets `ld_out_o[g*8+i]` where g*8+i<10.
    - Group 1 therefore writes bits 8..9 only.
  - DONE, 1 cycle: `done`=1. Next state is IDLE.
- `sel_h_o` stays 1 from LOAD_WO through DONE.
- `sel_reg`=g is held for the whole of each CLR/RUN/WB group.
- CLR: `rst_cnt`=1 for 1 cycle. This clears the PU accumulators and the datapath counter.
- RUN(base, N) has steps s=0..N+1:
  - `ld_mult` = (s<N).
  - `ld_add` = (1≤s≤N).
  - `acc` = (2≤s≤N+1).
  - `sel_64bit` = base+min(s, N−1).
  - `cnt`=1 on every RUN step.
- Invariants:
  - `ld`, `ld_out_h` and `ld_out_o` are each at most one-hot, except WB, which is group-wide.
  - `ld_x` is never high in the same cycle as any `ld*` bit.
  - `mem_read`=0 outside the load states.
- `start` is ignored while `busy`=1. `start` and `rst` in the same cycle: reset wins.

## Timing
- Let cycle 0 be the cycle in which `start` is sampled in IDLE. Cycle map:
  - 1: LOAD_X
  - 2–31: LOAD_WH
  - 32–79: hidden groups, 12 cycles each
  - 80–89: LOAD_WO
  - 90: LOAD_XO
  - 91–106: output groups, 8 cycles each
  - 107: DONE, `done`=1
- `busy` is high in cycles 1–107. A new `start` is accepted from cycle 108.
- PU pipeline contract:
  - Products are registered on `ld_mult`.
  - The adder tree is registered on `ld_add` one cycle later.
  - The accumulator updates on `acc` one cycle after that.
  - PU output (bias plus activation) is combinational and valid in WB.

## Structure
- Shared package/include `mlp_pkg` holds:
  - State encoding.
  - Constants `N_HID`, `N_OUT`, `N_PU`, `HID_CHUNKS`=8, `OUT_CHUNK_BASE`=4, `OUT_CHUNKS`=4, `PIPE_DEPTH`=2.
- One sub-module `mlp_group_seq`:
  - Inputs: `go`, `base[2:0]`, `len[3:0]`.
  - Generates the CLR/RUN/WB sequence: `rst_cnt`, `cnt`, `ld_mult`, `ld_add`, `acc`, `sel_64bit`, `wb` strobe.
  - Reused by both layers.
- Top-level FSM owns the load counters, the group index and the one-hot decode.

## Test plan
- Reset → every output 0 and `busy`=0. Hold `start`=1 for 3 cycles during `rst` → no state change.
- `start` with `sample_idx`=0x2A5 → cycle 1: `addr3`=0x2A5 and `ld_x`=1. Cycles 2..31: `ld`=1<<(c−2) and `addr1`=c−2.
- Hidden group 0 (cycles 32–43) → cycle 33 `sel_64bit`=0 with `ld_mult`=1. Cycle 40: `sel_64bit`=7. Cycle 42: `acc`=1 and `ld_mult`=0. Cycle 43: `ld_out_h`=0x000000FF.
- Hidden group 3 WB (cycle 79) → `ld_out_h`=0x3F000000 and `sel_reg`=3. Output group 1 WB (cycle 106) → `ld_out_o`=0x300.
- Full run against the datapath plus memory models with a known sample → `done` at cycle 107 exactly once, and `out` equals the golden-model argmax. `start` pulses at cycles 50 and 100 are ignored.
- `rst` asserted at cycle 60 → IDLE next cycle, outputs 0, no `done`. A fresh `start` then completes in 107 cycles.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants, state encodings and helpers for the MLP controller.
//   N_HID / N_OUT / N_PU  : layer sizes and processing-unit count
//   HID_CHUNKS, OUT_*     : 64-bit chunk schedule for the hidden and output layers
//   PIPE_DEPTH            : extra RUN steps needed to drain the PU mult/add pipeline
//   ctrl_state_t          : top-level sequencing states
//   seq_state_t           : per-group CLR/RUN/WB sequencer states
//   group_mask()          : write-back enable for one PU group, clipped to a layer size
package mlp_pkg;

  localparam int N_HID          = 30;
  localparam int N_OUT          = 10;
  localparam int N_PU           = 8;
  localparam int HID_CHUNKS     = 8;
  localparam int OUT_CHUNK_BASE = 4;
  localparam int OUT_CHUNKS     = 4;
  localparam int PIPE_DEPTH     = 2;
  localparam int HID_GROUPS     = (N_HID + N_PU - 1) / N_PU;
  localparam int OUT_GROUPS     = (N_OUT + N_PU - 1) / N_PU;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_X,
    ST_LOAD_WH,
    ST_HID_GRP,
    ST_LOAD_WO,
    ST_LOAD_XO,
    ST_OUT_GRP,
    ST_DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_WB
  } seq_state_t;

  // The last group of a layer is only partly populated, so neurons past the
  // layer size must not be written.
  function automatic logic [N_HID-1:0] group_mask(input logic [1:0] grp, input int limit);
    logic [N_HID-1:0] m;
    int               idx;
    m = '0;
    for (int i = 0; i < N_PU; i++) begin
      idx = int'(grp) * N_PU + i;
      if (idx < limit) m[idx[4:0]] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mlp_controller_if.sv
// mlp_controller_if: start/done handshake plus the datapath control bus.
//   master modport : controller side (receives start/sample_idx, drives the rest)
//   slave modport  : top-level/datapath side
interface mlp_controller_if;
  import mlp_pkg::*;

  logic             start;
  logic [9:0]       sample_idx;
  logic             busy;
  logic             done;
  logic             mem_read;
  logic             ld_x;
  logic             sel_h_o;
  logic             acc;
  logic             ld_add;
  logic             ld_mult;
  logic             rst_cnt;
  logic             cnt;
  logic [4:0]       addr1;
  logic [3:0]       addr2;
  logic [9:0]       addr3;
  logic [2:0]       sel_64bit;
  logic [2:0]       sel_reg;
  logic [N_HID-1:0] ld;
  logic [N_HID-1:0] ld_out_h;
  logic [N_OUT-1:0] ld_out_o;

  modport master (
    input  start, sample_idx,
    output busy, done, mem_read, ld_x, sel_h_o, acc, ld_add, ld_mult, rst_cnt, cnt,
           addr1, addr2, addr3, sel_64bit, sel_reg, ld, ld_out_h, ld_out_o
  );

  modport slave (
    output start, sample_idx,
    input  busy, done, mem_read, ld_x, sel_h_o, acc, ld_add, ld_mult, rst_cnt, cnt,
           addr1, addr2, addr3, sel_64bit, sel_reg, ld, ld_out_h, ld_out_o
  );

endinterface

// File: rtl/mlp_group_seq.sv
// mlp_group_seq: runs one PU group as CLR -> RUN -> WB, shared by both layers.
//   clk, rst  : clock and synchronous active-high reset
//   go        : held high by the parent while a layer's groups are being run;
//               the idle cycle with go high is the CLR cycle
//   base, len : first 64-bit chunk and number of chunks for this layer
//   rst_cnt, cnt, ld_mult, ld_add, acc, sel_64bit : PU pipeline controls
//   wb        : one-cycle write-back strobe at the end of the group
module mlp_group_seq
  import mlp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] base,
  input  logic [3:0] len,
  output logic       rst_cnt,
  output logic       cnt,
  output logic       ld_mult,
  output logic       ld_add,
  output logic       acc,
  output logic [2:0] sel_64bit,
  output logic       wb
);

  seq_state_t state, next_state;
  logic [3:0] step, next_step;
  logic [3:0] last_step;
  logic [2:0] chunk;

  // RUN lasts len steps of issue plus PIPE_DEPTH steps to drain the pipeline.
  assign last_step = len + 4'(PIPE_DEPTH - 1);
  // The chunk select holds on the last chunk while the pipeline drains.
  assign chunk     = (step < len) ? step[2:0] : 3'(len - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
      step  <= '0;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  always_comb begin
    next_state = state;
    next_step  = step;
    rst_cnt    = 1'b0;
    cnt        = 1'b0;
    ld_mult    = 1'b0;
    ld_add     = 1'b0;
    acc        = 1'b0;
    sel_64bit  = '0;
    wb         = 1'b0;
    unique case (state)
      SEQ_IDLE: begin
        if (go) begin
          rst_cnt    = 1'b1;
          next_state = SEQ_RUN;
          next_step  = '0;
        end
      end
      SEQ_RUN: begin
        cnt       = 1'b1;
        ld_mult   = (step < len);
        ld_add    = (step >= 4'd1) && (step <= len);
        acc       = (step >= 4'(PIPE_DEPTH));
        sel_64bit = base + chunk;
        if (step == last_step) next_state = SEQ_WB;
        else                   next_step  = step + 4'd1;
      end
      SEQ_WB: begin
        wb         = 1'b1;
        next_state = SEQ_IDLE;
      end
      default: next_state = SEQ_IDLE;
    endcase
  end

endmodule

// File: rtl/mlp_controller.sv
// mlp_controller: sequencing FSM for the MLP datapath control bus.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mlp_controller_if.master -- start/sample_idx in; busy/done and
//              all datapath controls (loads, addresses, PU pipeline) out
// One inference: load sample, load hidden weights, 4 hidden groups, load output
// weights, capture hidden results, 2 output groups, then pulse done.
module mlp_controller
  import mlp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mlp_controller_if.master bus
);

  ctrl_state_t state, next_state;
  logic [4:0]  load_k;
  logic [1:0]  grp;
  logic [9:0]  idx_q;
  logic        hid_layer;
  logic        in_group;
  logic        last_grp_hit;
  logic [2:0]  seq_base;
  logic [3:0]  seq_len;
  logic        seq_rst_cnt, seq_cnt, seq_ld_mult, seq_ld_add, seq_acc, seq_wb;
  logic [2:0]  seq_sel;

  assign hid_layer    = (state == ST_HID_GRP);
  assign in_group     = hid_layer || (state == ST_OUT_GRP);
  assign last_grp_hit = hid_layer ? (grp == 2'(HID_GROUPS - 1)) : (grp == 2'(OUT_GROUPS - 1));
  assign seq_base     = hid_layer ? 3'd0 : 3'(OUT_CHUNK_BASE);
  assign seq_len      = hid_layer ? 4'(HID_CHUNKS) : 4'(OUT_CHUNKS);

  // go stays high for the whole layer so the next group's CLR follows WB directly.
  mlp_group_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .go        (in_group),
    .base      (seq_base),
    .len       (seq_len),
    .rst_cnt   (seq_rst_cnt),
    .cnt       (seq_cnt),
    .ld_mult   (seq_ld_mult),
    .ld_add    (seq_ld_add),
    .acc       (seq_acc),
    .sel_64bit (seq_sel),
    .wb        (seq_wb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Load counter, group index and latched sample address.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_k <= '0;
      grp    <= '0;
      idx_q  <= '0;
    end else begin
      if (state == ST_IDLE && bus.start) idx_q <= bus.sample_idx;
      if ((state == ST_LOAD_WH || state == ST_LOAD_WO) && next_state == state)
        load_k <= load_k + 5'd1;
      else
        load_k <= '0;
      if (!in_group || (seq_wb && last_grp_hit)) grp <= '0;
      else if (seq_wb)                           grp <= grp + 2'd1;
    end
  end

  always_comb begin
    next_state    = state;
    bus.busy      = (state != ST_IDLE);
    bus.done      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.ld_x      = 1'b0;
    bus.sel_h_o   = 1'b0;
    bus.acc       = 1'b0;
    bus.ld_add    = 1'b0;
    bus.ld_mult   = 1'b0;
    bus.rst_cnt   = 1'b0;
    bus.cnt       = 1'b0;
    bus.addr1     = '0;
    bus.addr2     = '0;
    bus.addr3     = '0;
    bus.sel_64bit = '0;
    bus.sel_reg   = '0;
    bus.ld        = '0;
    bus.ld_out_h  = '0;
    bus.ld_out_o  = '0;
    if (in_group) begin
      bus.sel_reg   = {1'b0, grp};
      bus.rst_cnt   = seq_rst_cnt;
      bus.cnt       = seq_cnt;
      bus.ld_mult   = seq_ld_mult;
      bus.ld_add    = seq_ld_add;
      bus.acc       = seq_acc;
      bus.sel_64bit = seq_sel;
    end
    unique case (state)
      ST_IDLE: begin
        if (bus.start) next_state = ST_LOAD_X;
      end
      ST_LOAD_X: begin
        bus.mem_read = 1'b1;
        bus.ld_x     = 1'b1;
        bus.addr3    = idx_q;
        next_state   = ST_LOAD_WH;
      end
      ST_LOAD_WH: begin
        bus.mem_read = 1'b1;
        bus.addr1    = load_k;
        bus.ld       = N_HID'(1) << load_k;
        if (load_k == 5'(N_HID - 1)) next_state = ST_HID_GRP;
      end
      ST_HID_GRP: begin
        if (seq_wb) bus.ld_out_h = group_mask(grp, N_HID);
        if (seq_wb && last_grp_hit) next_state = ST_LOAD_WO;
      end
      ST_LOAD_WO: begin
        bus.sel_h_o  = 1'b1;
        bus.mem_read = 1'b1;
        bus.addr2    = load_k[3:0];
        bus.ld       = N_HID'(1) << load_k;
        if (load_k == 5'(N_OUT - 1)) next_state = ST_LOAD_XO;
      end
      ST_LOAD_XO: begin
        // Re-using the x register to capture the hidden-layer results.
        bus.sel_h_o = 1'b1;
        bus.ld_x    = 1'b1;
        next_state  = ST_OUT_GRP;
      end
      ST_OUT_GRP: begin
        bus.sel_h_o = 1'b1;
        if (seq_wb) bus.ld_out_o = N_OUT'(group_mask(grp, N_OUT));
        if (seq_wb && last_grp_hit) next_state = ST_DONE;
      end
      ST_DONE: begin
        bus.sel_h_o = 1'b1;
        bus.done    = 1'b1;
        next_state  = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mlp_controller.sv
// tb_mlp_controller: scoreboard bench for mlp_controller.
// The stimulus process issues inferences and pushes the expected control vector
// for every cycle of each run (computed from the cycle map) into a queue; the
// monitor samples the bus on the falling edge and compares against the queue
// head whose cycle stamp is due, or against all-zero when nothing is due.
module tb_mlp_controller;
  import mlp_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mem_read;
    logic        ld_x;
    logic        sel_h_o;
    logic        acc;
    logic        ld_add;
    logic        ld_mult;
    logic        rst_cnt;
    logic        cnt;
    logic [4:0]  addr1;
    logic [3:0]  addr2;
    logic [9:0]  addr3;
    logic [2:0]  sel_64bit;
    logic [2:0]  sel_reg;
    logic [29:0] ld;
    logic [29:0] ld_out_h;
    logic [9:0]  ld_out_o;
  } ctrl_t;

  typedef struct {
    int    stamp;
    int    rel;
    ctrl_t v;
  } exp_t;

  localparam int RUN_CYCLES = 107;

  logic clk = 1'b0;
  logic rst;
  int   cyc           = 0;
  int   tests         = 0;
  int   fails         = 0;
  int   done_seen     = 0;
  int   done_expected = 0;
  exp_t exp_q[$];

  mlp_controller_if bus();

  mlp_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic ctrl_t observe();
    ctrl_t a;
    a.busy      = bus.busy;
    a.done      = bus.done;
    a.mem_read  = bus.mem_read;
    a.ld_x      = bus.ld_x;
    a.sel_h_o   = bus.sel_h_o;
    a.acc       = bus.acc;
    a.ld_add    = bus.ld_add;
    a.ld_mult   = bus.ld_mult;
    a.rst_cnt   = bus.rst_cnt;
    a.cnt       = bus.cnt;
    a.addr1     = bus.addr1;
    a.addr2     = bus.addr2;
    a.addr3     = bus.addr3;
    a.sel_64bit = bus.sel_64bit;
    a.sel_reg   = bus.sel_reg;
    a.ld        = bus.ld;
    a.ld_out_h  = bus.ld_out_h;
    a.ld_out_o  = bus.ld_out_o;
    return a;
  endfunction

  // Expected bus contents for cycle c of an inference (cycle 0 = start sampled).
  function automatic ctrl_t model(input int c, input logic [9:0] idx);
    ctrl_t e;
    int    g, p, s, n, base, limit;
    bit    grp_phase, out_layer;
    e = '0;
    grp_phase = 1'b0;
    out_layer = 1'b0;
    g = 0; p = 0; s = 0; n = 0; base = 0; limit = 0;
    e.busy = (c >= 1 && c <= RUN_CYCLES);
    if (c == 1) begin
      e.mem_read = 1'b1;
      e.ld_x     = 1'b1;
      e.addr3    = idx;
    end else if (c >= 2 && c <= 31) begin
      e.mem_read = 1'b1;
      e.addr1    = 5'(c - 2);
      e.ld       = 30'(1) << (c - 2);
    end else if (c >= 32 && c <= 79) begin
      grp_phase = 1'b1;
      g = (c - 32) / 12; p = (c - 32) % 12; n = 8; base = 0; limit = 30;
    end else if (c >= 80 && c <= 89) begin
      e.sel_h_o  = 1'b1;
      e.mem_read = 1'b1;
      e.addr2    = 4'(c - 80);
      e.ld       = 30'(1) << (c - 80);
    end else if (c == 90) begin
      e.sel_h_o = 1'b1;
      e.ld_x    = 1'b1;
    end else if (c >= 91 && c <= 106) begin
      grp_phase = 1'b1;
      out_layer = 1'b1;
      e.sel_h_o = 1'b1;
      g = (c - 91) / 8; p = (c - 91) % 8; n = 4; base = 4; limit = 10;
    end else if (c == 107) begin
      e.sel_h_o = 1'b1;
      e.done    = 1'b1;
    end
    if (grp_phase) begin
      e.sel_reg = 3'(g);
      if (p == 0) begin
        e.rst_cnt = 1'b1;
      end else if (p <= n + 2) begin
        s = p - 1;
        e.cnt       = 1'b1;
        e.ld_mult   = (s < n);
        e.ld_add    = (s >= 1 && s <= n);
        e.acc       = (s >= 2 && s <= n + 1);
        e.sel_64bit = 3'(base + ((s < n - 1) ? s : n - 1));
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (g * 8 + i < limit) begin
            if (out_layer) e.ld_out_o = e.ld_out_o | (10'(1) << (g * 8 + i));
            else           e.ld_out_h = e.ld_out_h | (30'(1) << (g * 8 + i));
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_output(input string name, input ctrl_t act, input ctrl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Monitor: every falling edge either retires the due expectation or checks idle.
  always @(negedge clk) begin
    ctrl_t act;
    exp_t  item;
    act = observe();
    if (act.done) done_seen++;
    if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
      item = exp_q.pop_front();
      check_output($sformatf("trace c=%0d", item.rel), act, item.v);
    end else begin
      check_output($sformatf("idle cyc=%0d", cyc), act, '0);
    end
  end

  // Issues start now; p1/p2 are in-run cycles that pulse start (must be ignored);
  // rst_at > 0 asserts rst during that cycle of the run.
  task automatic apply_stimulus(input logic [9:0] idx, input int p1, input int p2, input int rst_at);
    int   c0;
    int   last;
    exp_t item;
    bus.start      = 1'b1;
    bus.sample_idx = idx;
    c0   = cyc;
    last = (rst_at > 0) ? rst_at : RUN_CYCLES;
    for (int c = 1; c <= last; c++) begin
      item.stamp = c0 + c;
      item.rel   = c;
      item.v     = model(c, idx);
      exp_q.push_back(item);
    end
    if (rst_at == 0) done_expected++;
    for (int c = 1; c <= RUN_CYCLES; c++) begin
      @(posedge clk); #1;
      bus.start      = (c == p1 || c == p2);
      bus.sample_idx = 10'($urandom);
      if (rst_at > 0 && c == rst_at) begin
        rst       = 1'b1;
        bus.start = 1'b0;
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        rst = 1'b0;
        check_output("reset mid-run", observe(), '0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missed c=%0d got=none want=%h", item.rel, item.v);
    end
  endtask

  initial begin
    logic [9:0] idx;
    int         p1, p2, gap;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.sample_idx = '0;
    @(posedge clk); #1;

    // start held during reset must not launch a run
    bus.start      = 1'b1;
    bus.sample_idx = 10'h155;
    repeat (3) begin
      @(posedge clk); #1;
      check_output("reset hold", observe(), '0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_output("post-reset idle", observe(), '0);

    $display("[TB] directed run, sample 0x2A5, stray starts at 50 and 100");
    apply_stimulus(10'h2A5, 50, 100, 0);

    $display("[TB] random back-to-back runs");
    for (int r = 0; r < 4; r++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      idx = 10'($urandom);
      p1  = $urandom_range(1, RUN_CYCLES);
      p2  = $urandom_range(0, RUN_CYCLES);
      apply_stimulus(idx, p1, p2, 0);
    end

    $display("[TB] reset at cycle 60, then fresh run");
    apply_stimulus(10'($urandom), 50, 0, 60);
    repeat (3) begin
      @(posedge clk); #1;
    end
    apply_stimulus(10'($urandom), 0, 0, 0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check_int("done count", done_seen, done_expected);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
